// File: rtl/sha256_iter.sv
// sha256_iter: iterative multi-block SHA-256 compression engine.
// Accepts already-padded 512-bit blocks over a valid/ready handshake, evaluates
// ROUNDS_PER_CYCLE rounds per clock and chains the hash state across blocks.
// The digest is presented over a valid/ready handshake after the last block.
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active-low
//   in_valid    in_block/in_first/in_last are valid
//   in_ready    block can be accepted this cycle
//   in_block    padded block, W0 at [511:480] ... W15 at [31:0]
//   in_first    first block of a message (load IV before compressing)
//   in_last     last block of a message (emit digest after compressing)
//   out_valid   out_digest is valid
//   out_ready   consumer accepts digest
//   out_digest  H0 at [255:224] ... H7 at [31:0]
//   busy        high while compressing or finalising
//   dbg_round   index of the next round to execute (0..64)
module sha256_iter #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest,
    output logic         busy,
    output logic [6:0]   dbg_round
);

    localparam int unsigned ROUND_CYCLES = 64 / ROUNDS_PER_CYCLE;
    // dbg_round value during the final ROUND cycle
    localparam int unsigned LAST_ROUND   = (ROUND_CYCLES - 1) * ROUNDS_PER_CYCLE;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Illegal unroll factors stop elaboration
    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rpc
        $error("sha256_iter: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_OUT   = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [255:0]   hash_q, hash_d;     // chained H0..H7
    logic [255:0]   work_q, work_d;     // working variables a..h, a at [255:224]
    logic [511:0]   win_q, win_d;       // 16-word schedule window, oldest word at [511:480]
    logic [6:0]     round_q, round_d;
    logic           last_q, last_d;
    logic           in_ready_q, out_valid_q, busy_q;

    logic [255:0]   work_c;
    logic [511:0]   win_c;

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // One compression round plus one schedule step; returns {a..h, window}
    function automatic logic [767:0] round_step(input logic [255:0] st,
                                                input logic [511:0] win,
                                                input logic [31:0]  k);
        logic [31:0] a, b, c, d, e, f, g, h, w, t1, t2, w_new;
        a = st[255:224]; b = st[223:192]; c = st[191:160]; d = st[159:128];
        e = st[127:96];  f = st[95:64];   g = st[63:32];   h = st[31:0];
        w = win[511:480];
        t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
        // window slots 1, 9 and 14 hold W[t-15], W[t-7] and W[t-2] of the new word
        w_new = ssig1(win[63:32]) + win[223:192] + ssig0(win[479:448]) + w;
        return {t1 + t2, a, b, c, d + t1, e, f, g, win[479:0], w_new};
    endfunction

    // Chain ROUNDS_PER_CYCLE rounds starting at round_q
    always_comb begin
        work_c = work_q;
        win_c  = win_q;
        for (int j = 0; j < int'(ROUNDS_PER_CYCLE); j++) begin
            {work_c, win_c} = round_step(work_c, win_c, K[6'(round_q) + 6'(j)]);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        hash_d  = hash_q;
        work_d  = work_q;
        win_d   = win_q;
        round_d = round_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    win_d   = in_block;
                    last_d  = in_last;
                    round_d = 7'd0;
                    if (in_first) begin
                        hash_d = IV;
                        work_d = IV;
                    end else begin
                        work_d = hash_q;
                    end
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                work_d  = work_c;
                win_d   = win_c;
                round_d = round_q + 7'(ROUNDS_PER_CYCLE);
                if (round_q == 7'(LAST_ROUND)) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    hash_d[255 - 32*i -: 32] = hash_q[255 - 32*i -: 32] + work_q[255 - 32*i -: 32];
                end
                state_d = last_q ? S_OUT : S_IDLE;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered handshake flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            hash_q      <= IV;
            work_q      <= '0;
            win_q       <= '0;
            round_q     <= 7'd0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hash_q      <= hash_d;
            work_q      <= work_d;
            win_q       <= win_d;
            round_q     <= round_d;
            last_q      <= last_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_OUT);
            busy_q      <= (state_d == S_ROUND) || (state_d == S_FINAL);
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign dbg_round  = round_q;
    assign out_digest = hash_q;

endmodule

// File: doc/sha256_iter.md
Name: sha256_iter

Overview:
- Iterative, multi-block SHA-256 compression engine with a parametrised number of rounds unrolled per clock.
- Next-generation replacement for the fully unrolled registered wrapper: trades throughput for area and adds what that wrapper lacks:
  - valid/ready handshakes on input and output;
  - chaining of the hash state across 512-bit blocks.
- Message padding and length encoding are done upstream; this block consumes already-padded blocks only.

Parameters:
- ROUNDS_PER_CYCLE, 1, compression rounds evaluated per clock. Legal values are 1, 2, 4 and 8; any other value is an elaboration-time $error.
- ROUND_CYCLES, 64/ROUNDS_PER_CYCLE, derived localparam, not overridable.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-low
- in_valid  input  1  in_block/in_first/in_last are valid
- in_ready  output  1  block can be accepted this cycle
- in_block  input  512  padded block; W0 = [511:480], W15 = [31:0], big-endian words
- in_first  input  1  first block of a message: load IV before compressing
- in_last  input  1  last block of a message: emit digest after compressing
- out_valid  output  1  out_digest is valid
- out_ready  input  1  consumer accepts digest
- out_digest  output  256  H0 at [255:224] … H7 at [31:0]
- busy  output  1  high in ROUND or FINAL state
- dbg_round  output  7  index of next round to execute (0..64)

Behaviour:
- State machine: IDLE -> ROUND -> FINAL -> IDLE or OUT; OUT -> IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready:
    - capture W[0..15] from in_block and latch in_last;
    - if in_first: H and a..h are loaded with the IV (6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19);
    - otherwise a..h load from the current H;
    - dbg_round <= 0; go to ROUND.
- ROUND:
  - each cycle executes ROUNDS_PER_CYCLE chained rounds using K[dbg_round + j];
  - the W schedule is a 16-word shift window advanced ROUNDS_PER_CYCLE words per cycle (sigma0/sigma1 expansion, mod 2^32);
  - dbg_round increments by ROUNDS_PER_CYCLE;
  - when it reaches 64, go to FINAL.
  - Exactly ROUND_CYCLES cycles are spent in ROUND.
- FINAL (one cycle):
  - H[i] <= H[i] + a..h[i] mod 2^32;
  - go to OUT if the latched last flag is set, else IDLE.
- OUT:
  - out_valid = 1 and out_digest = H;
  - both are held stable until out_ready;
  - on out_valid & out_ready go to IDLE (out_valid drops next cycle).
- in_ready = 0 in ROUND, FINAL and OUT; in_valid is ignored there and the input is not consumed.
- out_digest always reflects H combinationally from registers; it is only meaningful while out_valid = 1.
- Latency: block accepted at cycle T.
  - Non-last block: in_ready is high again at T+ROUND_CYCLES+2.
  - Last block: out_valid is high from T+ROUND_CYCLES+2.
  - For ROUNDS_PER_CYCLE = 1 both events fall at T+66.
- in_first & in_last both set: single-block message.
- A non-first block with no preceding chain uses the current H (IV after reset). This is not an error.
- Reset (rst = 0 at a clock edge), including mid-ROUND, mid-FINAL or mid-OUT:
  - state IDLE, H = IV, a..h = 0, W = 0, dbg_round = 0, latched last flag = 0;
  - out_valid = 0, busy = 0, in_ready = 1 on the first cycle after reset is released;
  - an interrupted message produces no digest.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- "abc" (one padded block, first = 1, last = 1), out_ready = 1, ROUNDS_PER_CYCLE = 1 -> out_valid at T+66, digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Empty message (block 80000000 followed by zeros, first = last = 1) -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - block 1 with first = 1, last = 0: no out_valid; in_ready returns at T+66;
  - block 2 with first = 0, last = 1 -> digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- Backpressure: "abc" with out_ready held 0 for 20 cycles -> out_valid and out_digest stable throughout; in_ready = 0 throughout; exactly one transfer when out_ready rises.
- Reset mid-operation: assert rst = 0 at round 30 of an "abc" block, then resend "abc" -> no digest for the aborted block; correct "abc" digest for the resent one; first out_valid only after the resend.
- Repeat the "abc" and two-block tests for ROUNDS_PER_CYCLE = 2, 4 and 8 -> identical digests at latency T+64/R+2, i.e. T+34, T+18 and T+10.
